packet_stream_builder: RTL and testbench
========================================

// Module: packet_stream_builder
// PURPOSE
//  Successor to the single-shot packet maker: builds one header+checksum+data packet
//  per start strobe and streams it out one 32-bit word per beat over valid/ready.
//  Depth (DATA_WORDS) and message store size (NUM_SEGS) are parametrised.
//  The ones-complement checksum is computed sequentially, with full end-around carry.
//  Sits between the transmit FSM (seq/ack/flags/window, start) and the laser TX serialiser.
// PARAMETERS
//  DATA_WORDS  4   32-bit payload words per packet (1..16)
//  NUM_SEGS    5   message segments held in msg_in; segment k is sent when seq-isn-1 == k
// PORTS
//  clk        in   1                        system clock
//  reset      in   1                        asynchronous, active-high reset
//  isn        in   32                       initial sequence number
//  seq        in   32                       sequence number for this packet
//  ack        in   32                       acknowledgement number
//  flags      in   9                        TCP-style flags
//  window     in   16                       receive window
//  msg_in     in   NUM_SEGS*DATA_WORDS*32   message store; segment k = bits [(k+1)*DATA_WORDS*32-1 : k*DATA_WORDS*32]
//  start      in   1                        request packet; accepted only when idle=1
//  idle       out  1                        1 in S_IDLE
//  out_data   out  32                       packet word
//  out_valid  out  1                        out_data valid
//  out_ready  in   1                        downstream accepts the word (handshake = valid & ready)
//  out_last   out  1                        high with the final word
//  seg_oob    out  1                        registered at start; 1 if index >= NUM_SEGS (payload zeroed)
// BEHAVIOUR
//  Reset (async) -> S_IDLE; out_valid=0, out_last=0, out_data=0, seg_oob=0, idle=1. All internal registers are cleared.
//  Word order (N = 4+DATA_WORDS data-bearing words, total N+1):
//   w0=32'd0, w1=seq, w2=ack, w3={7'd0,flags,window}, w4={csum,16'd0},
//   w5..w(4+DATA_WORDS) = segment words, most-significant 32 bits of segment first.
//  index = seq - isn - 1 (32-bit modular arithmetic); index >= NUM_SEGS -> payload all zero, seg_oob=1.
//  S_IDLE: start=1 at an edge -> capture seq/ack/flags/window and the selected segment. Then clear acc and go to S_SUM.
//   Inputs may change after capture without affecting the packet.
//  S_SUM: one word per cycle over w0..w3 and the payload words (w4 excluded), N cycles.
//   acc(32b) += word[31:16] + word[15:0]. Then go to S_FOLD.
//  S_FOLD (1 cycle): f = acc[15:0]+acc[31:16] (17b); f2 = f[15:0]+f[16]; csum = ~f2[15:0].
//   Load w0 onto out_data, set out_valid=1, go to S_EMIT.
//  Latency: out_valid first high N+2 edges after the accepting edge (10 for defaults).
//  S_EMIT: while out_valid & !out_ready, out_data and out_last are held stable.
//   Each handshake advances the word pointer. out_last=1 exactly on w(N).
//   Handshake on the last word -> out_valid=0, out_last=0, state S_IDLE. idle rises the next cycle.
//  start while not idle is ignored; no queuing. start may be held high and is re-accepted on re-entry to S_IDLE.
//  Reset mid-packet aborts immediately; no partial packet is resumed.
// STRUCTURE
//  Package lasernet_pkg: HDR_WORDS=4, CSUM_WORD_IDX=4, state enum {S_IDLE,S_SUM,S_FOLD,S_EMIT},
//   header-word build function for {7'd0,flags,window}.
//  Sub-module csum16_fold: combinational 32b-acc -> 16b complemented checksum, reused by the RX checker.
//  Word mux (pointer -> word) is shared by S_SUM and S_EMIT.
// TESTING
//  1 isn=100, seq=101, ack=0, flags=0, window=0, msg zero, out_ready=1
//    -> 9 words 0,0x65,0,0,0xFF9A0000,0,0,0,0; out_last on word 9; out_valid 10 edges after start.
//  2 isn=0, seq=1, segment 0 all 0xFFFFFFFF, rest 0 -> word4 = 0xFFFE0000 (end-around carry exercised).
//  3 isn=0, seq=6, msg non-zero -> seg_oob=1; payload words 0; word4 = ~0x0006 -> 0xFFF90000.
//  4 Case 1 with out_ready toggled 1,0,0,1 pseudo-randomly -> words held stable while stalled.
//    Sequence identical to case 1; no word dropped or duplicated.
//  5 start pulsed during S_SUM and S_EMIT -> ignored. After out_last handshake, idle=1 next cycle.
//    A new start then yields a second correct packet.
//  6 Assert reset mid-S_EMIT (word 3) -> out_valid=0 asynchronously, idle=1.
//    A following start produces a complete fresh packet.

Source files
------------

// File: rtl/lasernet_pkg.sv
// Shared types and helpers for the laser link packet path.
// Holds the builder state encoding, header layout constants and header word packing.
package lasernet_pkg;

  localparam int HDR_WORDS     = 4;
  localparam int CSUM_WORD_IDX = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_FOLD,
    S_EMIT
  } state_t;

  function automatic logic [31:0] hdr_word(
    input logic [8:0]  flags,
    input logic [15:0] window
  );
    return {7'd0, flags, window};
  endfunction

endpackage

// File: rtl/csum16_fold.sv
// Folds a 32-bit sum of 16-bit halves into a complemented 16-bit checksum.
// Ports: acc (32-bit running sum) in, csum (16-bit ones-complement checksum) out.
module csum16_fold (
  input  logic [31:0] acc,
  output logic [15:0] csum
);

  logic [16:0] f;
  logic [15:0] f2;

  assign f    = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
  // f tops out at 0x1FFFE, so one end-around add cannot carry again
  assign f2   = f[15:0] + {15'd0, f[16]};
  assign csum = ~f2;

endmodule

// File: rtl/packet_stream_builder.sv
// Builds one header+checksum+payload packet per start and streams it over valid/ready.
// Ports: clk, reset, isn/seq/ack/flags/window/msg_in/start in; idle, out_* and seg_oob out.
module packet_stream_builder
  import lasernet_pkg::*;
#(
  parameter int DATA_WORDS = 4,
  parameter int NUM_SEGS   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [31:0]                      isn,
  input  logic [31:0]                      seq,
  input  logic [31:0]                      ack,
  input  logic [8:0]                       flags,
  input  logic [15:0]                      window,
  input  logic [NUM_SEGS*DATA_WORDS*32-1:0] msg_in,
  input  logic                             start,
  output logic                             idle,
  output logic [31:0]                      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             seg_oob
);

  localparam int         SW   = DATA_WORDS * 32;
  localparam int         N    = HDR_WORDS + DATA_WORDS;
  localparam logic [4:0] LAST = 5'(N);

  state_t          state, state_n;
  logic [31:0]     seq_q, ack_q, hdr_q;
  logic [SW-1:0]   seg_q, seg_sel;
  logic [15:0]     csum_q, csum_f;
  logic [31:0]     acc;
  logic [16:0]     half;
  logic [4:0]      ptr, sel;
  logic [31:0]     word;
  logic [31:0]     index;
  logic            oob;
  logic            hs;

  assign hs    = out_valid & out_ready;
  assign idle  = (state == S_IDLE);
  assign index = seq - isn - 32'd1;
  assign oob   = (index >= 32'(NUM_SEGS));

  always_comb begin
    seg_sel = '0;
    for (int k = 0; k < NUM_SEGS; k++)
      if (index == 32'(k))
        seg_sel = msg_in[k*SW +: SW];
  end

  // The summing pass skips the checksum slot
  assign sel = (state == S_SUM && ptr >= 5'(CSUM_WORD_IDX))
             ? ptr + 5'd1 : ptr;

  always_comb begin
    word = '0;
    unique case (1'b1)
      (sel == 5'd0): word = '0;
      (sel == 5'd1): word = seq_q;
      (sel == 5'd2): word = ack_q;
      (sel == 5'd3): word = hdr_q;
      (sel == 5'd4): word = {csum_q, 16'd0};
      (sel >= 5'd5): begin
        for (int j = 0; j < DATA_WORDS; j++)
          if (sel == 5'(5 + j))
            word = seg_q[(DATA_WORDS-j)*32-1 -: 32];
      end
      default: word = '0;
    endcase
  end

  csum16_fold u_fold (
    .acc  (acc),
    .csum (csum_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_SUM;
      S_SUM:  if (ptr == LAST) state_n = S_FOLD;
      S_FOLD: state_n = S_EMIT;
      S_EMIT: if (hs && out_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Summing is pipelined: half holds hi+lo of the previous word,
  // so acc lands one cycle after the last word is read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q     <= '0;
      ack_q     <= '0;
      hdr_q     <= '0;
      seg_q     <= '0;
      csum_q    <= '0;
      acc       <= '0;
      half      <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      seg_oob   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          seq_q   <= seq;
          ack_q   <= ack;
          hdr_q   <= hdr_word(flags, window);
          seg_q   <= seg_sel;
          seg_oob <= oob;
          acc     <= '0;
          half    <= '0;
          ptr     <= '0;
        end
        S_SUM: begin
          acc <= acc + 32'(half);
          if (ptr != LAST) begin
            half <= {1'b0, word[31:16]} + {1'b0, word[15:0]};
            ptr  <= ptr + 5'd1;
          end
        end
        S_FOLD: begin
          csum_q    <= csum_f;
          out_data  <= '0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          ptr       <= 5'd1;
        end
        S_EMIT: if (hs) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end else begin
            out_data <= word;
            out_last <= (ptr == LAST);
            ptr      <= ptr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_stream_builder.sv
// Randomised self-checking bench for packet_stream_builder against a packet model.
// Drives and samples on the falling clock edge.
module tb_packet_stream_builder;

  localparam int DW = 4;
  localparam int NS = 5;
  localparam int N  = 4 + DW;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         isn, seq, ack;
  logic [8:0]          flags;
  logic [15:0]         window;
  logic [NS*DW*32-1:0] msg_in;
  logic                start;
  logic                idle;
  logic [31:0]         out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                seg_oob;

  int errors = 0;
  int checks = 0;

  logic [31:0] segs [NS][DW];
  logic [31:0] exp_w [N+1];
  logic        exp_oob;

  always #5 clk = ~clk;

  packet_stream_builder #(.DATA_WORDS(DW), .NUM_SEGS(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .isn       (isn),
    .seq       (seq),
    .ack       (ack),
    .flags     (flags),
    .window    (window),
    .msg_in    (msg_in),
    .start     (start),
    .idle      (idle),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .seg_oob   (seg_oob)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pack_msg();
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < DW; j++)
        msg_in[k*DW*32 + (DW-1-j)*32 +: 32] = segs[k][j];
  endtask

  task automatic fill_segs(input int mode);
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < DW; j++)
        segs[k][j] = (mode == 0) ? 32'd0 : $urandom;
  endtask

  // Packet as a list of words; checksum by repeated end-around folding.
  task automatic model(input logic [31:0] i_isn, input logic [31:0] i_seq,
                       input logic [31:0] i_ack, input logic [8:0] f,
                       input logic [15:0] w);
    logic [31:0] idx;
    longint      sum;
    idx = i_seq - i_isn - 32'd1;
    exp_oob = (idx >= NS);
    exp_w[0] = 32'd0;
    exp_w[1] = i_seq;
    exp_w[2] = i_ack;
    exp_w[3] = {7'd0, f, w};
    exp_w[4] = 32'd0;
    for (int j = 0; j < DW; j++)
      exp_w[5+j] = exp_oob ? 32'd0 : segs[int'(idx)][j];
    sum = 0;
    for (int k = 0; k <= N; k++)
      if (k != 4)
        sum += longint'(exp_w[k][31:16]) + longint'(exp_w[k][15:0]);
    while (sum > 'hFFFF)
      sum = (sum & 'hFFFF) + (sum >> 16);
    exp_w[4] = {~sum[15:0], 16'd0};
  endtask

  task automatic run_pkt(input logic [31:0] i_isn, input logic [31:0] i_seq,
                         input logic [31:0] i_ack, input logic [8:0] f,
                         input logic [15:0] w, input bit stall,
                         input bit poke, input bit abort);
    int          lat;
    int          k;
    int          cyc;
    bit          rdy;
    logic [31:0] held;
    logic        hl;
    model(i_isn, i_seq, i_ack, f, w);
    @(negedge clk);
    check("idle_pre", idle, 1);
    pack_msg();
    isn = i_isn; seq = i_seq; ack = i_ack; flags = f; window = w;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    isn = $urandom; seq = $urandom; ack = $urandom;
    flags = 9'($urandom); window = 16'($urandom);
    msg_in = {NS*DW{$urandom}};
    check("seg_oob", seg_oob, exp_oob);
    lat = 0;
    while (!out_valid && lat < 40) begin
      start = poke && lat == 3;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, N + 2);
    k = 0;
    cyc = 0;
    while (k <= N && cyc < 200) begin
      cyc++;
      check($sformatf("valid_w%0d", k), out_valid, 1);
      check($sformatf("data_w%0d", k), out_data, exp_w[k]);
      check($sformatf("last_w%0d", k), out_last, (k == N));
      if (abort && k == 3) begin
        #2 reset = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_idle", idle, 1);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      rdy = stall ? bit'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      start = poke && k == 3;
      held = out_data;
      hl = out_last;
      @(negedge clk);
      start = 1'b0;
      if (rdy) k++;
      else begin
        check("hold_data", out_data, held);
        check("hold_last", out_last, hl);
      end
    end
    check("words", k, N + 1);
    check("done_valid", out_valid, 0);
    check("done_idle", idle, 1);
  endtask

  initial begin
    logic [31:0] ri;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    isn = '0; seq = '0; ack = '0; flags = '0; window = '0;
    fill_segs(0);
    pack_msg();
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_oob", seg_oob, 0);
    check("rst_idle", idle, 1);
    reset = 1'b0;

    run_pkt(32'd100, 32'd101, 32'd0, 9'd0, 16'd0, 0, 0, 0);

    for (int j = 0; j < DW; j++) segs[0][j] = 32'hFFFF_FFFF;
    run_pkt(32'd0, 32'd1, 32'd0, 9'd0, 16'd0, 0, 0, 0);

    fill_segs(1);
    run_pkt(32'd0, 32'd6, 32'd0, 9'd0, 16'd0, 0, 0, 0);

    fill_segs(0);
    run_pkt(32'd100, 32'd101, 32'd0, 9'd0, 16'd0, 1, 0, 0);

    fill_segs(1);
    run_pkt(32'd7, 32'd10, $urandom, 9'h1A5, 16'hBEEF, 0, 1, 0);
    run_pkt(32'd7, 32'd9, $urandom, 9'h011, 16'h1234, 0, 0, 0);

    run_pkt(32'd50, 32'd52, $urandom, 9'h0F0, 16'h8000, 0, 0, 1);
    run_pkt(32'd50, 32'd55, $urandom, 9'h1FF, 16'hFFFF, 0, 0, 0);

    repeat (8) begin
      fill_segs(1);
      ri = $urandom;
      run_pkt(ri, ri + 32'd1 + 32'($urandom_range(0, 6)), $urandom,
              9'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
